// File: rtl/ysyx_23060059_axi_rd_arbiter.sv
// AXI4-Lite read-channel arbiter: icache refill (m0) and LSU load (m1) share one read master.
// Define YSYX_23060059_ARB_RR_EN for round-robin grant in IDLE; otherwise m1 has fixed priority.
module ysyx_23060059_axi_rd_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    input  logic [AW-1:0] m0_araddr,
    input  logic          m0_lock,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    input  logic [AW-1:0] m1_araddr,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          axi_arvalid,
    input  logic          axi_arready,
    output logic [AW-1:0] axi_araddr,
    input  logic          axi_rvalid,
    output logic          axi_rready,
    input  logic [DW-1:0] axi_rdata,
    input  logic [1:0]    axi_rresp
);
    // state     | meaning
    // IDLE      | no grant, arbitrate pending requests
    // ADDR_M0   | AR channel steered to icache (also waits between locked beats)
    // ADDR_M1   | AR channel steered to LSU
    // DATA_M0   | R channel steered to icache
    // DATA_M1   | R channel steered to LSU
    localparam int LW = $clog2(LOCK_MAX) + 1;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_M0 = 3'd1;
    localparam logic [2:0] S_ADDR_M1 = 3'd2;
    localparam logic [2:0] S_DATA_M0 = 3'd3;
    localparam logic [2:0] S_DATA_M1 = 3'd4;
    localparam logic [LW-1:0] LOCK_LIM  = LW'(LOCK_MAX);
    localparam logic [1:0]    RESP_OKAY = 2'b00;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [LW-1:0] lcnt_inc;
    logic          grant_m1;

    assign lcnt_inc = lcnt_q + LW'(1);

`ifdef YSYX_23060059_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On contention, grant whichever master did not win the previous IDLE arbitration.
    assign grant_m1 = m1_arvalid && (!m0_arvalid || !last_grant_q);
`else
    assign grant_m1 = m1_arvalid;
`endif

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
`ifdef YSYX_23060059_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_m1) begin
                    state_d = S_ADDR_M1;
`ifdef YSYX_23060059_ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (m0_arvalid) begin
                    state_d = S_ADDR_M0;
`ifdef YSYX_23060059_ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            S_ADDR_M0: begin
                if (m0_arvalid && axi_arready) begin
                    state_d = S_DATA_M0;
                end else if (!m0_arvalid && !m0_lock) begin
                    state_d = S_IDLE;
                    lcnt_d  = '0;
                end
            end
            S_ADDR_M1: begin
                if (m1_arvalid && axi_arready) state_d = S_DATA_M1;
            end
            S_DATA_M0: begin
                if (axi_rvalid && m0_rready) begin
                    // Hold the grant only while the refill is clean and under the beat limit.
                    if (m0_lock && axi_rresp == RESP_OKAY && lcnt_inc < LOCK_LIM) begin
                        state_d = S_ADDR_M0;
                        lcnt_d  = lcnt_inc;
                    end else begin
                        state_d = S_IDLE;
                        lcnt_d  = '0;
                    end
                end
            end
            S_DATA_M1: begin
                if (axi_rvalid && m1_rready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                lcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            lcnt_q  <= '0;
`ifdef YSYX_23060059_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
`ifdef YSYX_23060059_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        axi_arvalid = 1'b0;
        axi_araddr  = '0;
        axi_rready  = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m0_rdata    = '0;
        m0_rresp    = 2'b00;
        m1_rvalid   = 1'b0;
        m1_rdata    = '0;
        m1_rresp    = 2'b00;
        case (state_q)
            S_ADDR_M0: begin
                axi_arvalid = m0_arvalid;
                axi_araddr  = m0_araddr;
                m0_arready  = axi_arready;
            end
            S_ADDR_M1: begin
                axi_arvalid = m1_arvalid;
                axi_araddr  = m1_araddr;
                m1_arready  = axi_arready;
            end
            S_DATA_M0: begin
                axi_rready = m0_rready;
                m0_rvalid  = axi_rvalid;
                m0_rdata   = axi_rdata;
                m0_rresp   = axi_rresp;
            end
            S_DATA_M1: begin
                axi_rready = m1_rready;
                m1_rvalid  = axi_rvalid;
                m1_rdata   = axi_rdata;
                m1_rresp   = axi_rresp;
            end
            default: ;
        endcase
    end

endmodule
